karate_anim_sequencer: RTL and testbench



---
 rtl/karate_anim_sequencer_if.sv | 27 ++
 rtl/karate_anim_sequencer.sv | 222 ++++++++++++++++++++++
 tb/tb_karate_anim_sequencer.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/karate_anim_sequencer_if.sv
// Control bundle between the karate game sequencer and its neighbours.
// master: the sequencer; slave: keyboard/beat logic plus the colour mapper.
interface karate_anim_sequencer_if;
    logic        frame_tick;
    logic        game_go;
    logic        song_done;
    logic        move_valid;
    logic [1:0]  move_type;
    logic        move_ready;
    logic        hit_valid;
    logic [7:0]  hit_pts;
    logic [1:0]  start;
    logic [3:0]  enable;
    logic        activate;
    logic        end_screen;
    logic [15:0] score;

    modport master (
        input  frame_tick, game_go, song_done, move_valid, move_type, hit_valid, hit_pts,
        output move_ready, start, enable, activate, end_screen, score
    );

    modport slave (
        output frame_tick, game_go, song_done, move_valid, move_type, hit_valid, hit_pts,
        input  move_ready, start, enable, activate, end_screen, score
    );
endinterface

// File: rtl/karate_anim_sequencer.sv
// Game-phase and animation-frame sequencer feeding the colour mapper.
// Define KARATE_MOVE_QUEUE_EN to add a one-entry move buffer that chains moves back to back.
//
// state   | meaning
// TITLE   | title screen, start blinks 01/10
// READY   | ready screen (start=11) for READY_FRAMES frames
// PLAY    | gameplay, animation engine and scoring active
// END     | results screen until a fresh game_go press
module karate_anim_sequencer #(
    parameter int FRAMES_PER_STEP = 4,
    parameter int BLINK_FRAMES    = 30,
    parameter int READY_FRAMES    = 60
) (
    input  logic Clk,
    input  logic Reset,
    karate_anim_sequencer_if.master bus
);

    typedef enum logic [1:0] {S_TITLE, S_READY, S_PLAY, S_END} state_t;

    localparam logic [7:0] STEP_TC  = 8'(FRAMES_PER_STEP - 1);
    localparam logic [7:0] BLINK_TC = 8'(BLINK_FRAMES - 1);
    localparam logic [7:0] READY_TC = 8'(READY_FRAMES - 1);

    function automatic logic [3:0] first_code(input logic [1:0] t);
        case (t)
            2'd0:    first_code = 4'b0001;
            2'd1:    first_code = 4'b0100;
            2'd2:    first_code = 4'b1000;
            default: first_code = 4'b1110;
        endcase
    endfunction

    // Codes are contiguous within a move, so only the last code of each needs naming.
    function automatic logic is_last(input logic [3:0] c);
        is_last = (c == 4'b0011) || (c == 4'b0111) || (c == 4'b1101) || (c == 4'b1111);
    endfunction

    function automatic logic is_strike(input logic [3:0] c);
        is_strike = (c == 4'b0010) || (c == 4'b0110) || (c == 4'b1011) || (c == 4'b1111);
    endfunction

    state_t      state_q, state_d;
    logic [1:0]  start_q, start_d;
    logic [3:0]  enable_q, enable_d;
    logic        activate_q, activate_d;
    logic        end_screen_q, end_screen_d;
    logic [15:0] score_q, score_d;
    logic [7:0]  phase_q, phase_d;
    logic [7:0]  step_q, step_d;
    logic        go_q;
    logic        go_rise;
    logic        move_ready;
    logic        accept;
    logic [16:0] score_sum;
`ifdef KARATE_MOVE_QUEUE_EN
    logic        buf_v_q, buf_v_d;
    logic [1:0]  buf_t_q, buf_t_d;
    logic        direct_load;
`endif

    assign go_rise   = bus.game_go & ~go_q;
    assign score_sum = {1'b0, score_q} + {9'd0, bus.hit_pts};
`ifdef KARATE_MOVE_QUEUE_EN
    assign move_ready = (state_q == S_PLAY) && !buf_v_q && !bus.song_done;
`else
    assign move_ready = (state_q == S_PLAY) && (enable_q == 4'd0) && !bus.song_done;
`endif
    assign accept = bus.move_valid && move_ready;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q      <= S_TITLE;
            start_q      <= 2'b01;
            enable_q     <= 4'd0;
            activate_q   <= 1'b0;
            end_screen_q <= 1'b0;
            score_q      <= 16'd0;
            phase_q      <= 8'd0;
            step_q       <= 8'd0;
            go_q         <= 1'b0;
`ifdef KARATE_MOVE_QUEUE_EN
            buf_v_q      <= 1'b0;
            buf_t_q      <= 2'd0;
`endif
        end else begin
            state_q      <= state_d;
            start_q      <= start_d;
            enable_q     <= enable_d;
            activate_q   <= activate_d;
            end_screen_q <= end_screen_d;
            score_q      <= score_d;
            phase_q      <= phase_d;
            step_q       <= step_d;
            go_q         <= bus.game_go;
`ifdef KARATE_MOVE_QUEUE_EN
            buf_v_q      <= buf_v_d;
            buf_t_q      <= buf_t_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_TITLE: if (bus.game_go) state_d = S_READY;
            S_READY: if (bus.frame_tick && phase_q == READY_TC) state_d = S_PLAY;
            S_PLAY:  if (bus.song_done) state_d = S_END;
            S_END:   if (go_rise) state_d = S_TITLE;
            default: state_d = S_TITLE;
        endcase
    end

    always_comb begin
        start_d      = start_q;
        enable_d     = enable_q;
        end_screen_d = end_screen_q;
        score_d      = score_q;
        phase_d      = phase_q;
        step_d       = step_q;
`ifdef KARATE_MOVE_QUEUE_EN
        buf_v_d      = buf_v_q;
        buf_t_d      = buf_t_q;
        direct_load  = 1'b0;
`endif
        case (state_q)
            S_TITLE: begin
                if (bus.game_go) begin
                    start_d = 2'b11;
                    score_d = 16'd0;
                    phase_d = 8'd0;
                end else if (bus.frame_tick) begin
                    if (phase_q == BLINK_TC) begin
                        phase_d = 8'd0;
                        start_d = (start_q == 2'b01) ? 2'b10 : 2'b01;
                    end else begin
                        phase_d = phase_q + 8'd1;
                    end
                end
            end
            S_READY: begin
                if (bus.frame_tick) begin
                    if (phase_q == READY_TC) begin
                        phase_d = 8'd0;
                        start_d = 2'b00;
                    end else begin
                        phase_d = phase_q + 8'd1;
                    end
                end
            end
            S_PLAY: begin
                if (bus.hit_valid)
                    score_d = score_sum[16] ? 16'hFFFF : score_sum[15:0];
                if (bus.song_done) begin
                    enable_d     = 4'd0;
                    step_d       = 8'd0;
                    end_screen_d = 1'b1;
`ifdef KARATE_MOVE_QUEUE_EN
                    buf_v_d      = 1'b0;
`endif
                end else begin
                    if (enable_q == 4'd0) begin
                        if (accept) begin
                            enable_d = first_code(bus.move_type);
                            step_d   = 8'd0;
                        end
                    end else if (bus.frame_tick) begin
                        if (step_q == STEP_TC) begin
                            step_d = 8'd0;
                            if (is_last(enable_q)) begin
`ifdef KARATE_MOVE_QUEUE_EN
                                // Chain straight into the next move so no idle frame is shown.
                                if (buf_v_q) begin
                                    enable_d = first_code(buf_t_q);
                                    buf_v_d  = 1'b0;
                                end else if (accept) begin
                                    enable_d    = first_code(bus.move_type);
                                    direct_load = 1'b1;
                                end else begin
                                    enable_d = 4'd0;
                                end
`else
                                enable_d = 4'd0;
`endif
                            end else begin
                                enable_d = enable_q + 4'd1;
                            end
                        end else begin
                            step_d = step_q + 8'd1;
                        end
                    end
`ifdef KARATE_MOVE_QUEUE_EN
                    if (accept && enable_q != 4'd0 && !direct_load) begin
                        buf_v_d = 1'b1;
                        buf_t_d = bus.move_type;
                    end
`endif
                end
            end
            S_END: begin
                if (go_rise) begin
                    start_d      = 2'b01;
                    end_screen_d = 1'b0;
                    phase_d      = 8'd0;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        activate_d = is_strike(enable_d);
    end

    assign bus.move_ready = move_ready;
    assign bus.start      = start_q;
    assign bus.enable     = enable_q;
    assign bus.activate   = activate_q;
    assign bus.end_screen = end_screen_q;
    assign bus.score      = score_q;

endmodule

// File: tb/tb_karate_anim_sequencer.sv
// Scoreboard bench for karate_anim_sequencer: stimulus queues expected outputs, a monitor checks them.
module tb_karate_anim_sequencer;

`ifdef KARATE_MOVE_QUEUE_EN
    localparam bit QM = 1'b1;
`else
    localparam bit QM = 1'b0;
`endif

    logic Clk;
    logic Reset;
    karate_anim_sequencer_if bus();

    karate_anim_sequencer #(
        .FRAMES_PER_STEP(2),
        .BLINK_FRAMES(3),
        .READY_FRAMES(4)
    ) dut (
        .Clk(Clk),
        .Reset(Reset),
        .bus(bus)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct {
        int          at;
        string       nm;
        logic [1:0]  st;
        logic [3:0]  en;
        logic        act;
        logic        es;
        logic [15:0] sc;
        logic        mr;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    logic [1:0]  e_start;
    logic [3:0]  e_en;
    logic        e_act;
    logic        e_end;
    logic [15:0] e_sc;
    logic        e_mr;

    always @(posedge Clk) cyc <= cyc + 1;

    always @(negedge Clk) begin
        while (q.size() > 0 && q[0].at <= cyc) begin
            mon_e = q.pop_front();
            checks++;
            if ({bus.start, bus.enable, bus.activate, bus.end_screen, bus.score, bus.move_ready} !==
                {mon_e.st, mon_e.en, mon_e.act, mon_e.es, mon_e.sc, mon_e.mr}) begin
                errors++;
                $display("FAIL %s @%0d: got start=%b enable=%b act=%b end=%b score=%h ready=%b, want start=%b enable=%b act=%b end=%b score=%h ready=%b",
                         mon_e.nm, cyc, bus.start, bus.enable, bus.activate, bus.end_screen, bus.score, bus.move_ready,
                         mon_e.st, mon_e.en, mon_e.act, mon_e.es, mon_e.sc, mon_e.mr);
            end
        end
    end

    task automatic step(input string nm);
        exp_t e;
        e.at = cyc + 1; e.nm = nm; e.st = e_start; e.en = e_en; e.act = e_act;
        e.es = e_end; e.sc = e_sc; e.mr = e_mr;
        q.push_back(e);
        @(posedge Clk);
        @(negedge Clk);
        #1;
        bus.frame_tick = 1'b0;
        bus.song_done  = 1'b0;
        bus.hit_valid  = 1'b0;
        bus.move_valid = 1'b0;
    endtask

    task automatic tick_pair(input string nm);
        bus.frame_tick = 1'b1;
        step(nm);
        step({nm, "_gap"});
    endtask

    task automatic ready_phase();
        for (int i = 1; i <= 4; i++) begin
            bus.frame_tick = 1'b1;
            if (i == 4) begin e_start = 2'b00; e_mr = 1'b1; end
            step("ready");
            step("ready_gap");
        end
    endtask

    task automatic play_move(input logic [1:0] t, input logic [3:0] first, input int n,
                             input logic [3:0] strike, input string nm);
        bus.move_valid = 1'b1;
        bus.move_type  = t;
        e_en  = first;
        e_act = 1'b0;
        e_mr  = QM;
        step({nm, "_hs"});
        for (int k = 0; k < n; k++) begin
            for (int h = 0; h < 2; h++) begin
                bus.frame_tick = 1'b1;
                if (h == 1) begin
                    if (k == n - 1) begin e_en = 4'd0; e_mr = 1'b1; end
                    else e_en = e_en + 4'd1;
                    e_act = (e_en == strike);
                end
                step(nm);
                step({nm, "_gap"});
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, got cycle %0d want completion", cyc);
        $fatal(1);
    end

    logic [15:0] sat_exp [5];

    initial begin
        Reset = 1'b1;
        bus.frame_tick = 1'b0; bus.game_go = 1'b0; bus.song_done = 1'b0;
        bus.move_valid = 1'b0; bus.move_type = 2'd0; bus.hit_valid = 1'b0; bus.hit_pts = 8'd0;
        e_start = 2'b01; e_en = 4'd0; e_act = 1'b0; e_end = 1'b0; e_sc = 16'd0; e_mr = 1'b0;
        sat_exp[0] = 16'd65200; sat_exp[1] = 16'd65400; sat_exp[2] = 16'hFFFF;
        sat_exp[3] = 16'hFFFF;  sat_exp[4] = 16'hFFFF;
        @(negedge Clk); #1;
        step("reset");
        step("reset2");
        Reset = 1'b0;
        step("rst_release");

        for (int i = 1; i <= 6; i++) begin
            if (i == 3) e_start = 2'b10;
            if (i == 6) e_start = 2'b01;
            tick_pair("blink");
        end

        bus.hit_valid = 1'b1; bus.hit_pts = 8'd50;
        step("title_hit");

        bus.game_go = 1'b1; bus.frame_tick = 1'b1; e_start = 2'b11;
        step("go_ready");
        ready_phase();

        play_move(2'd0, 4'b0001, 3, 4'b0010, "jab");
        play_move(2'd1, 4'b0100, 4, 4'b0110, "rpunch");
        play_move(2'd3, 4'b1110, 2, 4'b1111, "upper");

        bus.hit_valid = 1'b1; bus.hit_pts = 8'd100; e_sc = 16'd100;
        step("hit100");

        bus.move_valid = 1'b1; bus.move_type = 2'd2; e_en = 4'b1000; e_mr = QM;
        step("crouch_hs");
        for (int i = 1; i <= 4; i++) begin
            if (i == 2) e_en = 4'b1001;
            if (i == 4) e_en = 4'b1010;
            tick_pair("crouch");
        end
        bus.song_done = 1'b1; bus.hit_valid = 1'b1; bus.hit_pts = 8'd7;
        e_en = 4'd0; e_act = 1'b0; e_end = 1'b1; e_sc = 16'd107; e_mr = 1'b0;
        step("song_done");
        step("end_hold");
        step("end_hold2");
        bus.game_go = 1'b0;
        step("end_release");
        bus.game_go = 1'b1; e_start = 2'b01; e_end = 1'b0;
        step("end_restart");
        bus.game_go = 1'b0; bus.hit_valid = 1'b1; bus.hit_pts = 8'd9;
        step("title_hit2");

        bus.game_go = 1'b1; e_start = 2'b11; e_sc = 16'd0;
        step("go_ready2");
        bus.game_go = 1'b0;
        ready_phase();

        for (int i = 0; i < 254; i++) begin
            bus.hit_valid = 1'b1; bus.hit_pts = 8'd255; e_sc = e_sc + 16'd255;
            step("score_ramp");
        end
        bus.hit_valid = 1'b1; bus.hit_pts = 8'd230; e_sc = 16'd65000;
        step("score_65000");
        for (int i = 0; i < 5; i++) begin
            bus.hit_valid = 1'b1; bus.hit_pts = 8'd200; e_sc = sat_exp[i];
            step("score_sat");
        end

`ifdef KARATE_MOVE_QUEUE_EN
        bus.move_valid = 1'b1; bus.move_type = 2'd3; e_en = 4'b1110; e_mr = 1'b1;
        step("q_up_hs");
        tick_pair("q_up");
        e_en = 4'b1111; e_act = 1'b1;
        tick_pair("q_up");
        bus.move_valid = 1'b1; bus.move_type = 2'd0; e_mr = 1'b0;
        step("q_buf");
        bus.move_valid = 1'b1; bus.move_type = 2'd2;
        step("q_full");
        tick_pair("q_hold");
        e_en = 4'b0001; e_act = 1'b0; e_mr = 1'b1;
        tick_pair("q_chain");
        for (int k = 0; k < 3; k++) begin
            tick_pair("q_jab");
            e_en = (k == 2) ? 4'd0 : e_en + 4'd1;
            e_act = (e_en == 4'b0010);
            tick_pair("q_jab");
        end
`endif

        bus.move_valid = 1'b1; bus.move_type = 2'd0; e_en = 4'b0001; e_mr = QM;
        step("rst_mid_hs");
        tick_pair("rst_mid_tick");
        Reset = 1'b1;
        e_start = 2'b01; e_en = 4'd0; e_act = 1'b0; e_end = 1'b0; e_sc = 16'd0; e_mr = 1'b0;
        step("rst_mid");
        Reset = 1'b0;
        step("rst_after");

        for (int i = 0; i < 5 && q.size() > 0; i++) @(negedge Clk);
        #1;
        if (q.size() > 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expectations, want 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
